// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding
// and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer that brings the asynchronous RX line into the clk domain.
// Flops reset low so the line is never treated as idle-high before it really is.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with ready/valid output and sticky overrun flag.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around its center.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int BASE_FREQ   = 50_000_000,
  parameter int BAUDRATE    = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB = BASE_FREQ / BAUDRATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CPB - 1) / 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  logic rx_s;
  logic rx_d1;
  logic rx_bit;

  uart_sync2 u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (serial_in),
    .sync_out (rx_s)
  );

  // Both builds look at the line one cycle late so rx_d1 is the "center"
  // sample and the voting build has its center+1 neighbour available.
`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b0;
      rx_d2 <= 1'b0;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign rx_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d1 <= 1'b0;
    end else begin
      rx_d1 <= rx_s;
    end
  end

  assign rx_bit = rx_d1;
`endif

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_acc, par_acc_n;
  logic                 perr_acc, perr_acc_n;
  logic                 ferr_acc, ferr_acc_n;
  logic                 armed;
  logic                 done;
  logic                 tick;

  assign tick = (cnt == CNT_LAST);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_acc  <= par_acc_n;
      perr_acc <= perr_acc_n;
      ferr_acc <= ferr_acc_n;
    end
  end

  // A start bit is only believed after the line has been seen idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (done) begin
      armed <= 1'b0;
    end else if (rx_bit) begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_acc_n  = par_acc;
    perr_acc_n = perr_acc;
    ferr_acc_n = ferr_acc;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (armed && !rx_bit) begin
          state_n = ST_START;
        end
      end

      ST_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          if (!rx_bit) begin
            state_n    = ST_DATA;
            par_acc_n  = 1'b0;
            perr_acc_n = 1'b0;
            ferr_acc_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_DATA: begin
        if (tick) begin
          cnt_n     = '0;
          shreg_n   = {rx_bit, shreg[DATA_BITS-1:1]};
          par_acc_n = par_acc ^ rx_bit;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          state_n = ST_STOP;
          if (PARITY_MODE == PARITY_ODD) begin
            perr_acc_n = ((par_acc ^ rx_bit) != 1'b1);
          end else begin
            perr_acc_n = ((par_acc ^ rx_bit) != 1'b0);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_STOP: begin
        if (tick) begin
          cnt_n      = '0;
          ferr_acc_n = ferr_acc | ~rx_bit;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            done      = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // A completed frame is dropped only if the held word cannot leave this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else begin
        out_data   <= shreg;
        parity_err <= perr_acc;
        frame_err  <= ferr_acc_n;
        out_valid  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
